control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches 16-bit instructions from a combinational ROM
// and sequences register-file, data-memory and ALU control as a Moore FSM.
module control_unit #(
  parameter int unsigned PC_W = 7
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [15:0]     IR_in,
  output logic [PC_W-1:0] PC_addr,
  output logic [7:0]      D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      State
);

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ALU_OP = 4'd7,
    HALT   = 4'd8
  } state_t;

  state_t          state, next_state;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH) begin
        ir <= IR_in;
        pc <= pc + PC_W'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:   next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: begin
        // Any opcode outside the defined set falls through to NOOP.
        if (ir[15])                  next_state = ALU_OP;
        else if (ir[15:12] == 4'h1)  next_state = LOAD_A;
        else if (ir[15:12] == 4'h2)  next_state = STORE;
        else if (ir[15:12] == 4'h5)  next_state = HALT;
        else                         next_state = NOOP;
      end
      NOOP:   next_state = FETCH;
      LOAD_A: next_state = LOAD_B;
      LOAD_B: next_state = FETCH;
      STORE:  next_state = FETCH;
      ALU_OP: next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = INIT;
    endcase
  end

  always_comb begin
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = '0;
    case (state)
      // The write is held back to LOAD_B to cover the one-cycle data RAM read latency.
      LOAD_A, LOAD_B: begin
        D_addr    = ir[11:4];
        RF_s      = 1'b1;
        RF_W_addr = ir[3:0];
        RF_W_en   = (state == LOAD_B);
      end
      STORE: begin
        D_addr     = ir[7:0];
        RF_Ra_addr = ir[11:8];
        D_wr       = 1'b1;
      end
      ALU_OP: begin
        RF_Ra_addr = ir[11:8];
        RF_Rb_addr = ir[7:4];
        ALU_s0     = ir[14:12];
        RF_W_addr  = ir[3:0];
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC_addr = pc;
  assign State   = state;

endmodule
